// File: rtl/max7219_rx.sv
// max7219_rx
// Receive-side decoder for a daisy chain of NDEV MAX7219 LED drivers.
// It synchronizes the serial link (din/sclk/load) and shifts in 16*NDEV-bit
// frames. Each frame is latched on the LOAD rising edge and then emitted
// one 16-bit word per clock, device 0 (nearest the driver) first.
// Register writes update a shadow row image and per-device shutdown bits.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   din, sclk, load     asynchronous serial inputs (data, clock, LOAD/CS)
//   word_valid          one-cycle strobe, word_dev/word_addr/word_data valid
//   word_dev            device index of the word (0 = nearest to driver)
//   word_addr           register address, word[11:8]
//   word_data           register data, word[7:0]
//   frame_done          one-cycle strobe after the last word of a good frame
//   frame_err           one-cycle strobe on a rejected frame
//   busy                high while a frame is being emitted
//   image               row shadow, image[dev*64+(addr-1)*8 +: 8]
//   shutdown_n          per-device shutdown register bit 0
module max7219_rx #(
    parameter int NDEV        = 4,
    parameter int SYNC_STAGES = 2,
    localparam int DEV_W      = (NDEV > 1) ? $clog2(NDEV) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               sclk,
    input  logic               load,
    output logic               word_valid,
    output logic [DEV_W-1:0]   word_dev,
    output logic [3:0]         word_addr,
    output logic [7:0]         word_data,
    output logic               frame_done,
    output logic               frame_err,
    output logic               busy,
    output logic [NDEV*64-1:0] image,
    output logic [NDEV-1:0]    shutdown_n
);

    localparam int FRAME_BITS = 16 * NDEV;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] din_sync_reg;
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] load_sync_reg;
    logic                   sclk_prev_reg;
    logic                   load_prev_reg;

    logic din_s;
    logic sclk_s;
    logic load_s;
    logic sclk_rise;
    logic load_rise;
    logic load_fall;

    // LOAD idles high, so its chain resets to 1: otherwise releasing reset
    // with load high would look like a LOAD rising edge and flag an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_sync_reg  <= '0;
            sclk_sync_reg <= '0;
            load_sync_reg <= '1;
            sclk_prev_reg <= 1'b0;
            load_prev_reg <= 1'b1;
        end else begin
            din_sync_reg  <= {din_sync_reg[SYNC_STAGES-2:0], din};
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
            load_sync_reg <= {load_sync_reg[SYNC_STAGES-2:0], load};
            sclk_prev_reg <= sclk_s;
            load_prev_reg <= load_s;
        end
    end

    assign din_s     = din_sync_reg[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign load_s    = load_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign load_rise = load_s & ~load_prev_reg;
    assign load_fall = ~load_s & load_prev_reg;

    // ------------------------------------------------------------------
    // Shift path (independent of the emission FSM)
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (load_fall) begin
            // Only the count restarts; stale shift contents are harmless
            // because a good frame overwrites every bit.
            bit_cnt_reg <= '0;
        end else if (sclk_rise && !load_s) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], din_s};
            // Saturate one past a full frame so over-long frames stay
            // distinguishable from exact ones.
            if (bit_cnt_reg != CNT_W'(FRAME_BITS + 1)) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Emission FSM
    // ------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    logic   frame_start;

    logic [FRAME_BITS-1:0] hold_reg;
    logic [DEV_W-1:0]      dev_cnt_reg;
    logic [15:0]           cur_word;

    assign frame_start = load_rise && (state_reg == IDLE)
                         && (bit_cnt_reg == CNT_W'(FRAME_BITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (frame_start) state_next = EMIT;
            EMIT: if (dev_cnt_reg == DEV_W'(NDEV - 1)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word for the device currently being emitted; device 0 is the last
    // word shifted, i.e. the least significant 16 bits of the hold register.
    always_comb begin
        cur_word = 16'h0000;
        for (int d = 0; d < NDEV; d++) begin
            if (dev_cnt_reg == DEV_W'(d)) begin
                cur_word = hold_reg[d*16 +: 16];
            end
        end
    end

    logic             word_valid_reg;
    logic [DEV_W-1:0] word_dev_reg;
    logic [3:0]       word_addr_reg;
    logic [7:0]       word_data_reg;
    logic             frame_done_reg;
    logic             frame_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg       <= '0;
            dev_cnt_reg    <= '0;
            word_valid_reg <= 1'b0;
            word_dev_reg   <= '0;
            word_addr_reg  <= 4'h0;
            word_data_reg  <= 8'h00;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            word_valid_reg <= 1'b0;
            frame_done_reg <= (state_reg == DONE);
            // A LOAD rise that does not start a frame is either a bad bit
            // count or an overrun of a frame still being emitted.
            frame_err_reg  <= load_rise && !frame_start;
            if (frame_start) begin
                hold_reg    <= shift_reg;
                dev_cnt_reg <= '0;
            end
            if (state_reg == EMIT) begin
                word_valid_reg <= 1'b1;
                word_dev_reg   <= dev_cnt_reg;
                word_addr_reg  <= cur_word[11:8];
                word_data_reg  <= cur_word[7:0];
                dev_cnt_reg    <= dev_cnt_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-device register file; writes take the registered word so they
    // become visible the cycle after its word_valid strobe.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NDEV; gi++) begin : g_dev
            logic [63:0] rows_reg;
            logic        sd_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rows_reg <= '0;
                    sd_reg   <= 1'b0;
                end else if (word_valid_reg && word_dev_reg == DEV_W'(gi)) begin
                    for (int r = 0; r < 8; r++) begin
                        if (word_addr_reg == 4'(r + 1)) begin
                            rows_reg[r*8 +: 8] <= word_data_reg;
                        end
                    end
                    if (word_addr_reg == 4'hC) begin
                        sd_reg <= word_data_reg[0];
                    end
                end
            end

            assign image[gi*64 +: 64] = rows_reg;
            assign shutdown_n[gi]     = sd_reg;
        end
    endgenerate

    assign word_valid = word_valid_reg;
    assign word_dev   = word_dev_reg;
    assign word_addr  = word_addr_reg;
    assign word_data  = word_data_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_max7219_rx.sv
// Directed testbench for max7219_rx with a word scoreboard: expected words
// are queued when a frame is driven and popped when word_valid fires.
module tb_max7219_rx;

    localparam int NDEV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              din = 1'b0;
    logic              sclk = 1'b0;
    logic              load = 1'b1;
    logic              word_valid;
    logic [1:0]        word_dev;
    logic [3:0]        word_addr;
    logic [7:0]        word_data;
    logic              frame_done;
    logic              frame_err;
    logic              busy;
    logic [NDEV*64-1:0] image;
    logic [NDEV-1:0]   shutdown_n;

    max7219_rx #(.NDEV(NDEV), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .sclk       (sclk),
        .load       (load),
        .word_valid (word_valid),
        .word_dev   (word_dev),
        .word_addr  (word_addr),
        .word_data  (word_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy),
        .image      (image),
        .shutdown_n (shutdown_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] dev;
        logic [3:0] addr;
        logic [7:0] data;
    } word_t;

    word_t         exp_q[$];
    logic [255:0]  exp_image = '0;
    logic [3:0]    exp_sd = '0;
    int            vectors = 0;
    int            miscompares = 0;
    int            word_cnt = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        word_t e;
        if (word_valid === 1'b1) begin
            word_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_word observed=%0h expected=none", {word_dev, word_addr, word_data});
            end else begin
                e = exp_q.pop_front();
                check("word", 256'({word_dev, word_addr, word_data}), 256'(e));
                $display("word dev=%0d addr=%0h data=%02h", word_dev, word_addr, word_data);
            end
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic send_bit(input logic b);
        din = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Frame of n bits, v[n-1] first on the wire, bracketed by LOAD low/high.
    task automatic shift_frame(input logic [127:0] v, input int n);
        load = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
        load = 1'b1;
    endtask

    // Queue expected words and advance the register model.
    task automatic push_frame(input logic [63:0] v);
        logic [15:0] w;
        int a;
        for (int d = 0; d < NDEV; d++) begin
            w = v[d*16 +: 16];
            exp_q.push_back({2'(d), w[11:8], w[7:0]});
            a = int'(w[11:8]);
            if (a >= 1 && a <= 8) exp_image[d*64 + (a-1)*8 +: 8] = w[7:0];
            if (a == 12) exp_sd[d] = w[0];
        end
    endtask

    task automatic wait_busy();
        int n = 0;
        while (busy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b1) check("busy_timeout", 256'(busy), 256'(1));
    endtask

    task automatic run_good(input string tag, input logic [63:0] v, input logic overrun);
        int w0 = word_cnt, d0 = done_cnt, e0 = err_cnt;
        push_frame(v);
        shift_frame({64'h0, v}, 64);
        if (overrun) begin
            wait_busy();
            force dut.load_rise = 1'b1;
            @(negedge clk);
            release dut.load_rise;
        end
        repeat (30) @(negedge clk);
        check({tag, "_words"}, 256'(word_cnt - w0), 256'(NDEV));
        check({tag, "_done"}, 256'(done_cnt - d0), 256'(1));
        check({tag, "_err"}, 256'(err_cnt - e0), overrun ? 256'(1) : 256'(0));
        check({tag, "_queue"}, 256'(exp_q.size()), 256'(0));
        check({tag, "_image"}, image, exp_image);
        check({tag, "_sd"}, 256'(shutdown_n), 256'(exp_sd));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        $display("frame %s done: words=%0d err=%0d", tag, word_cnt - w0, err_cnt - e0);
    endtask

    task automatic run_bad(input string tag, input logic [127:0] v, input int n);
        int w0 = word_cnt, d0 = done_cnt, e0 = err_cnt;
        shift_frame(v, n);
        repeat (30) @(negedge clk);
        check({tag, "_words"}, 256'(word_cnt - w0), 256'(0));
        check({tag, "_done"}, 256'(done_cnt - d0), 256'(0));
        check({tag, "_err"}, 256'(err_cnt - e0), 256'(1));
        check({tag, "_image"}, image, exp_image);
        check({tag, "_sd"}, 256'(shutdown_n), 256'(exp_sd));
        $display("frame %s (%0d bits) rejected: err=%0d", tag, n, err_cnt - e0);
    endtask

    localparam logic [63:0] FRAME_A = {16'h0C01, 16'h0155, 16'h08AA, 16'h0C01};
    localparam logic [63:0] FRAME_B = {16'h0C00, 16'h0833, 16'h0211, 16'h01FF};

    initial begin
        int w0, d0, e0;

        // Reset held: serial activity must not reach any state.
        repeat (3) @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(1'(i & 1));
        load = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_image", image, 256'(0));
        check("rst_sd", 256'(shutdown_n), 256'(0));
        check("rst_strobes", 256'(word_cnt + done_cnt + err_cnt), 256'(0));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_err", 256'(err_cnt), 256'(0));
        $display("reset released");

        // Good frame.
        run_good("good_a", FRAME_A, 1'b0);
        check("good_a_sd_lit", 256'(shutdown_n), 256'(4'b1001));
        check("good_a_row_aa", 256'(image[64*1+56 +: 8]), 256'(8'hAA));
        check("good_a_row_55", 256'(image[128 +: 8]), 256'(8'h55));

        // Wrong bit counts.
        run_bad("short63", {64'h0, FRAME_B}, 63);
        run_bad("long65", {63'h0, 1'b1, FRAME_B}, 65);

        // sclk pulses with load high are ignored.
        w0 = word_cnt; d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (10) @(negedge clk);
        check("idle_sclk_strobes", 256'(word_cnt - w0 + done_cnt - d0 + err_cnt - e0), 256'(0));
        run_good("good_a2", FRAME_A, 1'b0);

        // Overrun during emission.
        run_good("overrun_b", FRAME_B, 1'b1);

        // No-op and control words on all devices.
        run_good("noop0000", {4{16'h0000}}, 1'b0);
        run_good("ctl0a0f", {4{16'h0A0F}}, 1'b0);
        run_good("ctl0f01", {4{16'h0F01}}, 1'b0);

        // Reset in the middle of emission aborts everything.
        shift_frame({64'h0, FRAME_A}, 64);
        wait_busy();
        rst_n = 1'b0;
        w0 = word_cnt; d0 = done_cnt; e0 = err_cnt;
        exp_q.delete();
        exp_image = '0;
        exp_sd = '0;
        repeat (20) @(negedge clk);
        check("midrst_strobes", 256'(word_cnt - w0 + done_cnt - d0 + err_cnt - e0), 256'(0));
        check("midrst_image", image, exp_image);
        check("midrst_sd", 256'(shutdown_n), 256'(exp_sd));
        check("midrst_busy", 256'(busy), 256'(0));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_release_err", 256'(err_cnt - e0), 256'(0));
        $display("reset during emission checked");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
